// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction fields in, datapath controls out, between controller and datapath
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       immext;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, immext
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, immext
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle Moore controller for a MIPS-subset datapath
module mc_controller (
    input  logic               clk_i,
    input  logic               reset_i,
    mc_controller_if.master    bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IEX     = 4'd10,
        S_IWB     = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    logic   pcwrite, branch, branchbne;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYP:                  state_d = S_RTYPEEX;
                    OP_BEQ:                   state_d = S_BEQEX;
                    OP_BNE:                   state_d = S_BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEX;
                    OP_J:                     state_d = S_JEX;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IEX:     state_d = S_IWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b010;
        bus.immext     = 1'b0;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        branchbne      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                bus.alusrcb = 2'b01;
                pcwrite     = 1'b1;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                branch         = (state_q == S_BEQEX);
                branchbne      = (state_q == S_BNEEX);
            end
            S_IEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                case (bus.op)
                    OP_ANDI: begin
                        bus.alucontrol = 3'b000;
                        bus.immext     = 1'b1;
                    end
                    OP_ORI: begin
                        bus.alucontrol = 3'b001;
                        bus.immext     = 1'b1;
                    end
                    default: bus.alucontrol = 3'b010;
                endcase
            end
            S_IWB: bus.regwrite = 1'b1;
            S_JEX: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch outcome is the only path from zero to an output
    assign bus.pcen = pcwrite | (branch & bus.zero) | (branchbne & ~bus.zero);
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized per-cycle check of controller outputs against an instruction-level model
module tb_mc_controller;
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic       immext;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mc_controller_if bus();

    mc_controller dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t observe();
        ctrl_t c;
        c.iord = bus.iord;           c.memwrite = bus.memwrite;
        c.irwrite = bus.irwrite;     c.regdst = bus.regdst;
        c.memtoreg = bus.memtoreg;   c.regwrite = bus.regwrite;
        c.alusrca = bus.alusrca;     c.alusrcb = bus.alusrcb;
        c.pcsrc = bus.pcsrc;         c.pcen = bus.pcen;
        c.alucontrol = bus.alucontrol; c.immext = bus.immext;
        return c;
    endfunction

    function automatic ctrl_t idle_w();
        ctrl_t c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic ctrl_t fetch_w();
        ctrl_t c = idle_w();
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pcen    = 1'b1;
        return c;
    endfunction

    // Expected control word per cycle of one instruction, FETCH first
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z, output ctrl_t q[$]);
        ctrl_t c;
        q = {};
        q.push_back(fetch_w());
        c = idle_w(); c.alusrcb = 2'b11;
        q.push_back(c);
        case (op)
            6'b100011, 6'b101011: begin
                c = idle_w(); c.alusrca = 1; c.alusrcb = 2'b10;
                q.push_back(c);
                if (op == 6'b100011) begin
                    c = idle_w(); c.iord = 1;
                    q.push_back(c);
                    c = idle_w(); c.memtoreg = 1; c.regwrite = 1;
                    q.push_back(c);
                end else begin
                    c = idle_w(); c.iord = 1; c.memwrite = 1;
                    q.push_back(c);
                end
            end
            6'b000000: begin
                c = idle_w(); c.alusrca = 1;
                case (fn)
                    6'b100010: c.alucontrol = 3'b110;
                    6'b100100: c.alucontrol = 3'b000;
                    6'b100101: c.alucontrol = 3'b001;
                    6'b101010: c.alucontrol = 3'b111;
                    default:   c.alucontrol = 3'b010;
                endcase
                q.push_back(c);
                c = idle_w(); c.regdst = 1; c.regwrite = 1;
                q.push_back(c);
            end
            6'b000100, 6'b000101: begin
                c = idle_w(); c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
                c.pcen = (op == 6'b000100) ? z : ~z;
                q.push_back(c);
            end
            6'b001000, 6'b001100, 6'b001101: begin
                c = idle_w(); c.alusrca = 1; c.alusrcb = 2'b10;
                if (op == 6'b001100) begin c.alucontrol = 3'b000; c.immext = 1; end
                if (op == 6'b001101) begin c.alucontrol = 3'b001; c.immext = 1; end
                q.push_back(c);
                c = idle_w(); c.regwrite = 1;
                q.push_back(c);
            end
            6'b000010: begin
                c = idle_w(); c.pcsrc = 2'b10; c.pcen = 1;
                q.push_back(c);
            end
            default: ;
        endcase
    endtask

    // Called at a negedge while the DUT is in FETCH; returns at the negedge of the next FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        ctrl_t q[$];
        int    nwr;
        model(op, fn, z, q);
        bus.op = op; bus.funct = fn; bus.zero = z;
        nwr = 0;
        foreach (q[i]) begin
            ctrl_t o;
            #1;
            o = observe();
            check($sformatf("op%02h_fn%02h_z%0d_c%0d", op, fn, z, i), 32'(o), 32'(q[i]));
            nwr += int'(o.memwrite) + int'(o.regwrite) + int'(o.irwrite);
            @(negedge clk);
        end
        if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101})
            check($sformatf("op%02h_writes", op), 32'(nwr), 32'd2);
        else
            check($sformatf("op%02h_writes", op), 32'(nwr), 32'd1);
        #1;
        check($sformatf("op%02h_back_to_fetch", op), 32'(observe()), 32'(fetch_w()));
    endtask

    localparam logic [5:0] KNOWN_OPS [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
        6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b000010};
    localparam logic [5:0] KNOWN_FN [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(observe()), 32'(fetch_w()));
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'b100011, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b100010, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1);
        run_instr(6'b000100, 6'b000000, 1'b0);
        run_instr(6'b000101, 6'b000000, 1'b1);
        run_instr(6'b000101, 6'b000000, 1'b0);
        run_instr(6'b001101, 6'b000000, 1'b0);
        run_instr(6'b111111, 6'b000000, 1'b0);

        // Asynchronous reset in the middle of the sw write cycle
        bus.op = 6'b101011; bus.funct = 6'b0; bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sw_memwr_before_reset", 32'(bus.memwrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_memwrite", 32'(bus.memwrite), 32'd0);
        check("async_reset_fetch", 32'(observe()), 32'(fetch_w()));
        @(negedge clk);
        #1;
        check("reset_held_fetch", 32'(observe()), 32'(fetch_w()));
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'b001000, 6'b000000, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : KNOWN_OPS[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : KNOWN_FN[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
